// File: rtl/reaction_timer_if.sv
// Player-facing signal bundle of the reaction timer.
//   start, stop        : debounced, synchronized buttons (master -> slave)
//   rd3..rd0           : BCD reaction time, thousands..ones in ms (slave -> master)
//   go_led, early_led  : status lamps (slave -> master)
//   done               : result frozen on rd3..rd0 (slave -> master)
interface reaction_timer_if;
    logic       start;
    logic       stop;
    logic [3:0] rd3;
    logic [3:0] rd2;
    logic [3:0] rd1;
    logic [3:0] rd0;
    logic       go_led;
    logic       early_led;
    logic       done;

    modport master (
        output start, stop,
        input  rd3, rd2, rd1, rd0, go_led, early_led, done
    );

    modport slave (
        input  start, stop,
        output rd3, rd2, rd1, rd0, go_led, early_led, done
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time game: a start press arms a pseudo-random delay, then go_led
// lights and elapsed ticks are counted in BCD until stop is pressed.
//   clk : system clock
//   rst : synchronous, active-high reset
//   io  : reaction_timer_if.slave (start/stop in; rd3..rd0, go_led,
//         early_led, done out, all registered)
module reaction_timer #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned MIN_DELAY   = 1000,
    parameter int unsigned RAND_BITS   = 11
) (
    input  logic              clk,
    input  logic              rst,
    reaction_timer_if.slave   io
);

    localparam int unsigned DIV       = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned MAX_DELAY = MIN_DELAY + (1 << RAND_BITS) - 1;
    localparam int unsigned CNT_BITS  = $clog2(MAX_DELAY + 1);
    localparam int unsigned DLY_W     = (CNT_BITS > RAND_BITS + 1) ? CNT_BITS : RAND_BITS + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        TIMING = 3'd2,
        DONE   = 3'd3,
        EARLY  = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [PRE_W-1:0]  presc_q;
    logic [15:0]       lfsr_q;
    logic              start_q, stop_q;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [3:0][3:0]   dig_q, dig_d;     // [0]=ones .. [3]=thousands
    logic              go_q, go_d;
    logic              early_q, early_d;
    logic              done_q, done_d;

    logic start_e, stop_e, tick, lfsr_fb, carry;

    assign start_e = io.start & ~start_q;
    assign stop_e  = io.stop  & ~stop_q;
    assign tick    = (presc_q == PRE_W'(DIV - 1));
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    assign io.rd3       = dig_q[3];
    assign io.rd2       = dig_q[2];
    assign io.rd1       = dig_q[1];
    assign io.rd0       = dig_q[0];
    assign io.go_led    = go_q;
    assign io.early_led = early_q;
    assign io.done      = done_q;

    // Next-state and next-output logic; stop outranks a coincident tick.
    always_comb begin
        state_d = state;
        dly_d   = dly_q;
        dig_d   = dig_q;
        go_d    = go_q;
        early_d = early_q;
        done_d  = done_q;
        carry   = 1'b1;
        case (state)
            IDLE, DONE, EARLY: begin
                if (start_e) begin
                    dly_d   = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
                    dig_d   = '0;
                    done_d  = 1'b0;
                    early_d = 1'b0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (stop_e) begin
                    dig_d   = 16'h9999;
                    early_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = EARLY;
                end else if (tick) begin
                    if (dly_q == DLY_W'(1)) begin
                        go_d    = 1'b1;
                        dig_d   = '0;
                        state_d = TIMING;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
            end
            TIMING: begin
                if (stop_e) begin
                    go_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (tick) begin
                    if (dig_q == 16'h9999) begin
                        // saturate at the display limit instead of wrapping
                        go_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // ripple BCD increment, ones first
                        for (int i = 0; i < 4; i++) begin
                            if (carry) begin
                                if (dig_q[i] == 4'd9) begin
                                    dig_d[i] = 4'd0;
                                end else begin
                                    dig_d[i] = dig_q[i] + 4'd1;
                                    carry    = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, outputs, edge-detect and LFSR registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dly_q   <= '0;
            dig_q   <= '0;
            go_q    <= 1'b0;
            early_q <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            lfsr_q  <= 16'hACE1;
        end else begin
            state   <= state_d;
            dly_q   <= dly_d;
            dig_q   <= dig_d;
            go_q    <= go_d;
            early_q <= early_d;
            done_q  <= done_d;
            start_q <= io.start;
            stop_q  <= io.stop;
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // Tick prescaler; restarts on every state change so the first tick
    // lands a full period after entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (state_d != state || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

endmodule
